bft_leaf_tx: RTL and testbench

- Leaf-side transmitter for the BFT network: the injection end that drives a switch's leaf_N_in port and honours its resend_N back-pressure.
- Accepts payload words plus destination from a user operator over valid/ready and buffers them in a small FIFO.
- Builds 49-bit packets with a sequence number and presents them to the switch, holding and re-driving each packet until the switch accepts it.
- Keeps saturating statistics and raises a sticky stuck flag when a packet keeps being refused.

---
 rtl/bft_leaf_tx.sv | 129 ++++++++++++
 tb/tb_bft_leaf_tx.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/bft_leaf_tx.sv
// Leaf-side BFT injector: buffers user words in a small FIFO, stamps a sequence
// number, and re-drives each packet into the switch until resend_i releases it.
module bft_leaf_tx #(
  parameter int PAYLOAD_W  = 32,
  parameter int ADDR_W     = 5,
  parameter int PORT_W     = 3,
  parameter int SEQ_W      = 8,
  parameter int PACKET_W   = 49,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_RETRY  = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PAYLOAD_W-1:0] din_data,
  input  logic [ADDR_W-1:0]    din_dst_leaf,
  input  logic [PORT_W-1:0]    din_dst_port,
  input  logic                 din_valid,
  output logic                 din_ready,
  output logic [PACKET_W-1:0]  leaf_in_o,
  input  logic                 resend_i,
  output logic [15:0]          sent_cnt,
  output logic [15:0]          retry_cnt,
  output logic                 stuck_o,
  output logic                 idle_o
);
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int CONSEC_W = $clog2(MAX_RETRY + 1);
  localparam int ENTRY_W  = ADDR_W + PORT_W + PAYLOAD_W;

  logic [ENTRY_W-1:0]  mem_q [FIFO_DEPTH];
  logic [ENTRY_W-1:0]  mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PACKET_W-1:0] pkt_q, pkt_d;
  logic [SEQ_W-1:0]    seq_q, seq_d;
  logic [15:0]         sent_q, sent_d, retry_q, retry_d;
  logic [CONSEC_W-1:0] consec_q, consec_d;
  logic                stuck_q, stuck_d;

  logic               pkt_vld, fifo_empty, fifo_full, wr_en, refuse, accept;
  logic               load_ok, pop, bypass, fifo_wr;
  logic [ENTRY_W-1:0] head;

  assign pkt_vld    = pkt_q[PACKET_W-1];
  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign din_ready  = !reset && !fifo_full;
  assign wr_en      = din_valid && din_ready;
  assign refuse     = pkt_vld && resend_i;
  assign accept     = pkt_vld && !resend_i;
  assign load_ok    = !refuse;
  assign pop        = load_ok && !fifo_empty;
  // An empty FIFO feeding a free output slot skips storage to keep one-cycle latency.
  assign bypass     = load_ok && fifo_empty && wr_en;
  assign fifo_wr    = wr_en && !bypass;
  assign head       = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    pkt_d    = pkt_q;
    seq_d    = seq_q;
    sent_d   = sent_q;
    retry_d  = retry_q;
    consec_d = consec_q;
    stuck_d  = stuck_q;

    if (fifo_wr) begin
      mem_d[wr_ptr_q] = {din_dst_leaf, din_dst_port, din_data};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (fifo_wr && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !fifo_wr) cnt_d = cnt_q - 1'b1;

    if (load_ok) begin
      if (pop)         pkt_d = {1'b1, head[ENTRY_W-1:PAYLOAD_W], seq_q, head[PAYLOAD_W-1:0]};
      else if (bypass) pkt_d = {1'b1, din_dst_leaf, din_dst_port, seq_q, din_data};
      else             pkt_d = '0;
      if (pop || bypass) seq_d = seq_q + 1'b1;
    end

    if (accept) begin
      consec_d = '0;
      if (sent_q != 16'hFFFF) sent_d = sent_q + 16'd1;
    end
    if (refuse) begin
      if (retry_q != 16'hFFFF) retry_d = retry_q + 16'd1;
      if (consec_q != CONSEC_W'(MAX_RETRY)) consec_d = consec_q + 1'b1;
      if (consec_q == CONSEC_W'(MAX_RETRY - 1)) stuck_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      pkt_q    <= '0;
      seq_q    <= '0;
      sent_q   <= '0;
      retry_q  <= '0;
      consec_q <= '0;
      stuck_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      pkt_q    <= pkt_d;
      seq_q    <= seq_d;
      sent_q   <= sent_d;
      retry_q  <= retry_d;
      consec_q <= consec_d;
      stuck_q  <= stuck_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) mem_q <= mem_d;

  assign leaf_in_o = pkt_q;
  assign sent_cnt  = sent_q;
  assign retry_cnt = retry_q;
  assign stuck_o   = stuck_q;
  assign idle_o    = fifo_empty && !pkt_vld;
endmodule

// File: tb/tb_bft_leaf_tx.sv
// Directed bench for bft_leaf_tx: vector table for the main flows, hand-written
// sequences for mid-operation reset and sequence-number wrap.
module tb_bft_leaf_tx;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] din_data;
  logic [4:0]  din_dst_leaf;
  logic [2:0]  din_dst_port;
  logic        din_valid;
  logic        din_ready;
  logic [48:0] leaf_in_o;
  logic        resend_i;
  logic [15:0] sent_cnt, retry_cnt;
  logic        stuck_o, idle_o;

  int checks = 0;
  int errors = 0;
  int row    = 0;

  bft_leaf_tx #(.MAX_RETRY(4)) dut (
    .clk(clk), .reset(reset), .din_data(din_data), .din_dst_leaf(din_dst_leaf),
    .din_dst_port(din_dst_port), .din_valid(din_valid), .din_ready(din_ready),
    .leaf_in_o(leaf_in_o), .resend_i(resend_i), .sent_cnt(sent_cnt),
    .retry_cnt(retry_cnt), .stuck_o(stuck_o), .idle_o(idle_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, dv, rs;
    logic [31:0] d;
    logic [4:0]  leaf;
    logic [2:0]  port;
    logic [48:0] e_pkt;
    logic        e_rdy, e_idle, e_stuck;
    logic [15:0] e_sent, e_retry;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [48:0] pk(input int k, input logic [7:0] s, input logic [31:0] d);
    return {1'b1, 5'(k), 3'(k), s, d};
  endfunction

  function automatic logic [31:0] wd(input int k);
    return 32'hA000_0000 + 32'(k);
  endfunction

  function automatic vec_t mk(input logic rst, input logic dv, input int k, input logic rs,
                              input logic [48:0] e_pkt, input logic e_rdy, input logic e_idle,
                              input int e_sent, input int e_retry, input logic e_stuck);
    vec_t v;
    v.rst = rst; v.dv = dv; v.rs = rs; v.d = wd(k); v.leaf = 5'(k); v.port = 3'(k);
    v.e_pkt = e_pkt; v.e_rdy = e_rdy; v.e_idle = e_idle;
    v.e_sent = 16'(e_sent); v.e_retry = 16'(e_retry); v.e_stuck = e_stuck;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic dv, input int k, input logic rs);
    reset = rst; din_valid = dv; resend_i = rs;
    din_data = wd(k); din_dst_leaf = 5'(k); din_dst_port = 3'(k);
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t v;
    logic [48:0] ep;
    // Single word: one-cycle latency, then idle.
    vecs.push_back(mk(1, 0, 0, 0, '0, 0, 1, 0, 0, 0));
    v = mk(0, 1, 0, 0, '0, 1, 1, 0, 0, 0);
    v.d = 32'hDEADBEEF; v.leaf = 5'd5; v.port = 3'd2;
    vecs.push_back(v);
    vecs.push_back(mk(0, 0, 0, 0, {1'b1, 5'd5, 3'd2, 8'd0, 32'hDEADBEEF}, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, '0, 1, 1, 1, 0, 0));
    // Eight back-to-back words, one packet per cycle.
    vecs.push_back(mk(1, 0, 0, 0, '0, 0, 1, 0, 0, 0));
    for (int t = 0; t <= 9; t++) begin
      ep = (t >= 1 && t <= 8) ? pk(t-1, 8'(t-1), wd(t-1)) : '0;
      vecs.push_back(mk(0, t < 8, t, 0, ep, 1, (t == 0 || t == 9), (t < 2) ? 0 : t-1, 0, 0));
    end
    // Three refusals of the first packet, then in-order drain.
    vecs.push_back(mk(1, 0, 0, 0, '0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, '0,                   1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, pk(0, 8'd0, wd(0)),   1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 2, 1, pk(0, 8'd0, wd(0)),   1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 3, 1, pk(0, 8'd0, wd(0)),   1, 0, 0, 2, 0));
    vecs.push_back(mk(0, 0, 0, 0, pk(0, 8'd0, wd(0)),   1, 0, 0, 3, 0));
    vecs.push_back(mk(0, 0, 0, 0, pk(1, 8'd1, wd(1)),   1, 0, 1, 3, 0));
    vecs.push_back(mk(0, 0, 0, 0, pk(2, 8'd2, wd(2)),   1, 0, 2, 3, 0));
    vecs.push_back(mk(0, 0, 0, 0, pk(3, 8'd3, wd(3)),   1, 0, 3, 3, 0));
    vecs.push_back(mk(0, 0, 0, 0, '0,                   1, 1, 4, 3, 0));
    // Four refusals set stuck; FIFO fills, and a full FIFO refuses a word even while popping.
    vecs.push_back(mk(1, 0, 0, 0, '0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, '0,                   1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, pk(0, 8'd0, wd(0)),   1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 2, 1, pk(0, 8'd0, wd(0)),   1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 3, 1, pk(0, 8'd0, wd(0)),   1, 0, 0, 2, 0));
    vecs.push_back(mk(0, 1, 4, 1, pk(0, 8'd0, wd(0)),   1, 0, 0, 3, 0));
    vecs.push_back(mk(0, 1, 5, 0, pk(0, 8'd0, wd(0)),   0, 0, 0, 4, 1));
    vecs.push_back(mk(0, 0, 0, 0, pk(1, 8'd1, wd(1)),   1, 0, 1, 4, 1));
    vecs.push_back(mk(0, 0, 0, 0, pk(2, 8'd2, wd(2)),   1, 0, 2, 4, 1));
    vecs.push_back(mk(0, 0, 0, 0, pk(3, 8'd3, wd(3)),   1, 0, 3, 4, 1));
    vecs.push_back(mk(0, 0, 0, 0, pk(4, 8'd4, wd(4)),   1, 0, 4, 4, 1));
    vecs.push_back(mk(0, 0, 0, 0, '0,                   1, 1, 5, 4, 1));

    drive(1, 0, 0, 0);
    next_cycle();
    foreach (vecs[i]) begin
      row = i;
      v = vecs[i];
      reset = v.rst; din_valid = v.dv; resend_i = v.rs;
      din_data = v.d; din_dst_leaf = v.leaf; din_dst_port = v.port;
      @(negedge clk);
      if (v.rst) chk("ready_in_reset", 64'(din_ready), 64'(0));
      else begin
        chk("leaf_in", 64'(leaf_in_o), 64'(v.e_pkt));
        chk("din_ready", 64'(din_ready), 64'(v.e_rdy));
        chk("idle", 64'(idle_o), 64'(v.e_idle));
        chk("stuck", 64'(stuck_o), 64'(v.e_stuck));
        chk("sent_cnt", 64'(sent_cnt), 64'(v.e_sent));
        chk("retry_cnt", 64'(retry_cnt), 64'(v.e_retry));
      end
      next_cycle();
    end

    // Reset with three words queued and the head packet being refused (stuck still set).
    row = 1000;
    drive(0, 1, 0, 0); next_cycle();
    for (int k = 1; k <= 3; k++) begin drive(0, 1, k, 1); next_cycle(); end
    drive(1, 1, 7, 1);
    @(negedge clk);
    chk("mid_reset_ready", 64'(din_ready), 64'(0));
    next_cycle();
    drive(0, 1, 9, 0);
    @(negedge clk);
    chk("mid_reset_pkt", 64'(leaf_in_o), 64'(0));
    chk("mid_reset_sent", 64'(sent_cnt), 64'(0));
    chk("mid_reset_retry", 64'(retry_cnt), 64'(0));
    chk("mid_reset_stuck", 64'(stuck_o), 64'(0));
    chk("mid_reset_idle", 64'(idle_o), 64'(1));
    next_cycle();
    drive(0, 0, 0, 0);
    @(negedge clk);
    chk("post_reset_seq0", 64'(leaf_in_o), 64'(pk(9, 8'd0, wd(9))));
    next_cycle();

    // 257 packets: sequence number wraps 255 -> 0.
    row = 2000;
    drive(1, 0, 0, 0); next_cycle();
    drive(0, 1, 0, 0); next_cycle();
    for (int i = 1; i <= 257; i++) begin
      if (i < 257) drive(0, 1, i, 0); else drive(0, 0, 0, 0);
      @(negedge clk);
      chk("wrap_pkt", 64'(leaf_in_o), 64'(pk(i-1, 8'(i-1), wd(i-1))));
      next_cycle();
    end
    @(negedge clk);
    chk("wrap_sent", 64'(sent_cnt), 64'(257));
    chk("wrap_idle", 64'(idle_o), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
